fp16_dot_sequencer: RTL and testbench



---
 rtl/fp16_pkg.sv | 11 +
 rtl/fp16_dot_sequencer_if.sv | 30 +++
 rtl/fp16_dot_lane_tracker.sv | 40 ++++
 rtl/fp16_dot_sequencer.sv | 123 ++++++++++++
 tb/tb_fp16_dot_sequencer.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 constants and the dot-sequencer state encoding.
package fp16_pkg;
  localparam int FP16_W     = 16;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;

  localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, REDUCE, DONE} state_t;
endpackage

// File: rtl/fp16_dot_sequencer_if.sv
// Operand, FMA and result channels of the dot sequencer.
// FP16_DOT_ACC_INIT_EN adds the acc_init input.
interface fp16_dot_sequencer_if #(parameter int LEN_W = 16);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
`ifdef FP16_DOT_ACC_INIT_EN
  logic [15:0]      acc_init;
`endif
  logic             op_valid, op_ready;
  logic [15:0]      op_a, op_b;
  logic             fma_in_valid;
  logic [15:0]      fma_a, fma_b, fma_c;
  logic             fma_out_valid;
  logic [15:0]      fma_out;
  logic             res_valid, res_ready;
  logic [15:0]      res_data;

`ifdef FP16_DOT_ACC_INIT_EN
  modport master (input start, len, acc_init, op_valid, op_a, op_b, fma_out_valid, fma_out, res_ready,
                  output busy, op_ready, fma_in_valid, fma_a, fma_b, fma_c, res_valid, res_data);
  modport slave  (output start, len, acc_init, op_valid, op_a, op_b, fma_out_valid, fma_out, res_ready,
                  input busy, op_ready, fma_in_valid, fma_a, fma_b, fma_c, res_valid, res_data);
`else
  modport master (input start, len, op_valid, op_a, op_b, fma_out_valid, fma_out, res_ready,
                  output busy, op_ready, fma_in_valid, fma_a, fma_b, fma_c, res_valid, res_data);
  modport slave  (output start, len, op_valid, op_a, op_b, fma_out_valid, fma_out, res_ready,
                  input busy, op_ready, fma_in_valid, fma_a, fma_b, fma_c, res_valid, res_data);
`endif
endinterface

// File: rtl/fp16_dot_lane_tracker.sv
// Tracks which lane each in-flight FMA op belongs to and which lanes await a result.
module fp16_dot_lane_tracker #(
  parameter int LANES = 4,
  parameter int LW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic [LW-1:0]    issue_lane,
  input  logic             fma_out_valid,
  output logic             ret,
  output logic [LW-1:0]    ret_lane,
  output logic [LANES-1:0] pending
);
  logic [LANES-1:0]         vld_pipe;
  logic [LANES-1:0][LW-1:0] lane_pipe;
  logic [LANES-1:0]         pending_n;

  // Oldest entry lines up with the FMA output; results with no tracked issue are dropped.
  assign ret      = vld_pipe[LANES-1] & fma_out_valid;
  assign ret_lane = lane_pipe[LANES-1];

  always_comb begin
    pending_n = pending;
    if (ret)   pending_n[ret_lane]   = 1'b0;
    if (issue) pending_n[issue_lane] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      lane_pipe <= '0;
      pending   <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[LANES-2:0], issue};
      lane_pipe <= {lane_pipe[LANES-2:0], issue_lane};
      pending   <= pending_n;
    end
  end
endmodule

// File: rtl/fp16_dot_sequencer.sv
// Dot-product sequencer: interleaves partial sums across FMA lanes, then reduces them.
// FP16_DOT_ACC_INIT_EN seeds lane 0 with acc_init.
module fp16_dot_sequencer import fp16_pkg::*; #(
  parameter int FMA_LATENCY = 4,
  parameter int LEN_W       = 16
) (
  input logic                  clk,
  input logic                  rst,
  fp16_dot_sequencer_if.master bus
);
  localparam int LW = (FMA_LATENCY > 1) ? $clog2(FMA_LATENCY) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(FMA_LATENCY - 1);

  state_t                         state, state_n;
  logic [LEN_W-1:0]               len_q, cnt;
  logic [LW-1:0]                  lane, red_idx, ret_lane, issue_lane;
  logic [FMA_LATENCY-1:0][15:0]   slot;
  logic [FMA_LATENCY-1:0]         pending;
  logic [15:0]                    acc, res_q, a_q, b_q, c_q, iss_a, iss_b, iss_c, init0;
  logic                           ret, lane_ret, issue, op_ready;

`ifdef FP16_DOT_ACC_INIT_EN
  assign init0 = bus.acc_init;
`else
  assign init0 = FP16_ZERO;
`endif

  fp16_dot_lane_tracker #(.LANES(FMA_LATENCY), .LW(LW)) u_tracker (
    .clk, .rst, .issue, .issue_lane,
    .fma_out_valid(bus.fma_out_valid),
    .ret, .ret_lane, .pending
  );

  assign lane_ret = ret && (ret_lane == lane);

  always_comb begin
    state_n    = state;
    op_ready   = 1'b0;
    issue      = 1'b0;
    issue_lane = lane;
    iss_a      = a_q;
    iss_b      = b_q;
    iss_c      = c_q;
    case (state)
      IDLE:   if (bus.start) state_n = (bus.len == '0) ? DONE : ACCUM;
      ACCUM: begin
        // A lane whose result lands this cycle is free again; forward the result as addend.
        op_ready = ~pending[lane] | lane_ret;
        issue    = bus.op_valid & op_ready;
        iss_a    = bus.op_a;
        iss_b    = bus.op_b;
        iss_c    = lane_ret ? bus.fma_out : slot[lane];
        if (issue && cnt == len_q - 1'b1) state_n = DRAIN;
      end
      DRAIN:  if (pending == '0) state_n = REDUCE;
      REDUCE: begin
        issue      = (pending == '0);
        issue_lane = red_idx;
        iss_a      = acc;
        iss_b      = FP16_ONE;
        iss_c      = slot[red_idx];
        if (ret && red_idx == LAST_LANE) state_n = DONE;
      end
      DONE:   if (bus.res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy         = (state != IDLE);
  assign bus.op_ready     = op_ready;
  assign bus.fma_in_valid = issue;
  assign bus.fma_a        = issue ? iss_a : a_q;
  assign bus.fma_b        = issue ? iss_b : b_q;
  assign bus.fma_c        = issue ? iss_c : c_q;
  assign bus.res_valid    = (state == DONE);
  assign bus.res_data     = res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      len_q   <= '0;
      cnt     <= '0;
      lane    <= '0;
      red_idx <= LW'(1);
      slot    <= '0;
      acc     <= FP16_ZERO;
      res_q   <= FP16_ZERO;
      a_q     <= FP16_ZERO;
      b_q     <= FP16_ZERO;
      c_q     <= FP16_ZERO;
    end else begin
      state <= state_n;
      a_q   <= bus.fma_a;
      b_q   <= bus.fma_b;
      c_q   <= bus.fma_c;
      case (state)
        IDLE: if (bus.start) begin
          len_q   <= bus.len;
          cnt     <= '0;
          lane    <= '0;
          red_idx <= LW'(1);
          slot[0] <= init0;
          res_q   <= init0;
        end
        ACCUM, DRAIN: begin
          if (ret) slot[ret_lane] <= bus.fma_out;
          if (issue) begin
            cnt  <= cnt + 1'b1;
            lane <= (lane == LAST_LANE) ? '0 : lane + 1'b1;
          end
          if (state_n == REDUCE) acc <= slot[0];
        end
        REDUCE: if (ret) begin
          acc     <= bus.fma_out;
          red_idx <= red_idx + 1'b1;
          if (red_idx == LAST_LANE) res_q <= bus.fma_out;
        end
        DONE: if (bus.res_ready) slot <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp16_dot_sequencer.sv
// Directed bench for fp16_dot_sequencer with a 4-cycle behavioural FP16 FMA.
module tb_fp16_dot_sequencer;
  import fp16_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   n_iss = 0;

  always #5 clk = ~clk;

  fp16_dot_sequencer_if #(.LEN_W(16)) bus();

  fp16_dot_sequencer #(.FMA_LATENCY(4), .LEN_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef FP16_DOT_ACC_INIT_EN
  initial bus.acc_init = 16'h0000;
`endif

  function automatic real p2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e = int'(h[14:10]);
    real m;
    if (e == 0) m = (real'(h[9:0]) / 1024.0) * p2(-14);
    else        m = (1.0 + real'(h[9:0]) / 1024.0) * p2(e - 15);
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real v);
    real         av;
    int          e, man;
    logic        s;
    logic [15:0] h;
    if (v == 0.0) return 16'h0000;
    s  = (v < 0.0);
    av = s ? -v : v;
    e  = 15;
    while (av >= 2.0) begin av = av / 2.0; e++; end
    while (av < 1.0)  begin av = av * 2.0; e--; end
    man = int'((av - 1.0) * 1024.0);
    if (man == 1024) begin man = 0; e++; end
    h = {s, e[4:0], man[9:0]};
    return h;
  endfunction

  // Behavioural FMA: result appears exactly 4 cycles after the issue strobe; not reset by rst.
  logic [3:0]       pv = '0;
  logic [3:0][15:0] pd = '0;
  always @(posedge clk) begin
    pv <= {pv[2:0], bus.fma_in_valid};
    pd <= {pd[2:0], r2h(h2r(bus.fma_a) * h2r(bus.fma_b) + h2r(bus.fma_c))};
  end
  assign bus.fma_out_valid = pv[3];
  assign bus.fma_out       = pd[3];

  always @(posedge clk) if (bus.fma_in_valid) n_iss <= n_iss + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input string tag, input int n, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp, input int hold, input int exp_iss);
    int base, sent, cyc, w, unstable;
    base = n_iss;
    @(negedge clk); bus.start = 1'b1; bus.len = 16'(n);
    @(negedge clk); bus.start = 1'b0;
    if (n == 0) chk({tag, "_next"}, 32'(bus.res_valid), 32'd1);
    bus.op_a = a; bus.op_b = b; bus.op_valid = (n != 0);
    sent = 0; cyc = 0;
    while (sent < n && cyc < 100) begin
      if (bus.op_ready) sent++;
      cyc++;
      @(negedge clk);
    end
    bus.op_valid = 1'b0;
    if (n != 0) chk({tag, "_cyc"}, 32'(cyc), 32'(n));
    w = 0;
    while (!bus.res_valid && w < 300) begin @(negedge clk); w++; end
    chk({tag, "_done"}, 32'(bus.res_valid), 32'd1);
    chk({tag, "_res"}, 32'(bus.res_data), 32'(exp));
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.res_valid || bus.res_data !== exp) unstable++;
    end
    if (hold > 0) chk({tag, "_hold"}, 32'(unstable), 32'd0);
    bus.res_ready = 1'b1;
    @(negedge clk); bus.res_ready = 1'b0;
    chk({tag, "_idle"}, 32'({bus.busy, bus.res_valid}), 32'd0);
    @(negedge clk);
    chk({tag, "_iss"}, 32'(n_iss - base), 32'(exp_iss));
  endtask

  initial begin
    int sent, cyc;
    rst = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.op_valid = 1'b0;
    bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.op_ready), 32'd0);
    chk("rst_fiv",   32'(bus.fma_in_valid), 32'd0);
    chk("rst_rv",    32'(bus.res_valid), 32'd0);
    chk("rst_rd",    32'(bus.res_data), 32'd0);
    chk("rst_fabc",  32'({bus.fma_a, bus.fma_b} | 32'(bus.fma_c)), 32'd0);
    rst = 1'b0;

    run_job("len1",  1, 16'h3C00, 16'h4000, 16'h4000, 0, 4);
    run_job("len4",  4, 16'h3C00, 16'h3C00, 16'h4400, 0, 7);
    run_job("len8",  8, 16'h3C00, 16'h3800, 16'h4400, 0, 11);
    run_job("len0",  0, 16'h3C00, 16'h3C00, 16'h0000, 0, 0);
    run_job("hold", 4, 16'h4000, 16'h3C00, 16'h4800, 10, 7);

    // Reset while lane results are still in flight, then a fresh job.
    @(negedge clk); bus.start = 1'b1; bus.len = 16'd4;
    @(negedge clk); bus.start = 1'b0;
    bus.op_a = 16'h3C00; bus.op_b = 16'h3C00; bus.op_valid = 1'b1;
    sent = 0; cyc = 0;
    while (sent < 4 && cyc < 100) begin
      if (bus.op_ready) sent++;
      cyc++;
      @(negedge clk);
    end
    bus.op_valid = 1'b0;
    chk("drain_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    run_job("post_rst", 1, 16'h3C00, 16'h3C00, 16'h3C00, 0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
